// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded mod-M counter: direction encodings and a
// digit-width helper that never returns zero, even for M=2.
// No ports; imported by modm_digit and modm_cascade_counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Smallest W with 2**W >= m, but at least 1 so a mod-2 digit still has a bit.
  function automatic int clog2_safe(input int m);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < m) begin
      v = v * 2;
      r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/modm_digit.sv
// Single mod-M digit register with up/down count, sync clear and clamped load.
// Ports: clk/rstb, cin (count this edge), up, clr, load, ld_val -> d (digit),
//        term (digit at its wrap value for the current direction), cout = cin & term.
module modm_digit
  import counter_pkg::*;
#(
  parameter int M = 10,
  parameter int W = clog2_safe(M)
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         cin,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] d,
  output logic         term,
  output logic         cout
);

  localparam logic [W-1:0] D_MAX  = W'(M - 1);
  localparam logic [W-1:0] D_ZERO = '0;
  localparam logic [W-1:0] D_ONE  = W'(1);

  logic [W-1:0] d_q;
  logic [W-1:0] d_d;

  // Terminal value depends on direction, so term follows up combinationally.
  always_comb begin
    term = (up == DIR_UP) ? (d_q == D_MAX) : (d_q == D_ZERO);
  end

  assign cout = cin & term;
  assign d    = d_q;

  always_comb begin
    d_d = d_q;
    if (clr) begin
      d_d = D_ZERO;
    end else if (load) begin
      // Out-of-range load values (only possible when M is not a power of 2)
      // saturate so the digit never leaves 0..M-1.
      d_d = (ld_val > D_MAX) ? D_MAX : ld_val;
    end else if (cin) begin
      if (up == DIR_UP) begin
        d_d = term ? D_ZERO : d_q + D_ONE;
      end else begin
        d_d = term ? D_MAX : d_q - D_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      d_q <= D_ZERO;
    end else begin
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/modm_cascade_counter.sv
// Chain of STAGES mod-M digits with up/down count, clear, load, carry ticks and sticky wrap flag.
// Ports: clk/rstb, clr, load, load_val, en, up -> q (packed digits, stage 0 = LS),
//        stage_tick (per-stage wrap this edge), max_tick (chain wrap this edge), wrap_flag.
module modm_cascade_counter
  import counter_pkg::*;
#(
  parameter int M      = 10,
  parameter int STAGES = 4,
  parameter int W      = clog2_safe(M)
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                clr,
  input  logic                load,
  input  logic [STAGES*W-1:0] load_val,
  input  logic                en,
  input  logic                up,
  output logic [STAGES*W-1:0] q,
  output logic [STAGES-1:0]   stage_tick,
  output logic                max_tick,
  output logic                wrap_flag
);

  // carry[i] means stage i advances on the coming edge; carry[STAGES] is the
  // whole-chain wrap. clr/load kill the chain at its root.
  logic [STAGES:0]   carry;
  logic [STAGES-1:0] term;
  logic              wrap_q;
  logic              wrap_d;

  assign carry[0] = en & ~clr & ~load;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    modm_digit #(
      .M (M),
      .W (W)
    ) u_digit (
      .clk    (clk),
      .rstb   (rstb),
      .cin    (carry[i]),
      .up     (up),
      .clr    (clr),
      .load   (load),
      .ld_val (load_val[i*W +: W]),
      .d      (q[i*W +: W]),
      .term   (term[i]),
      .cout   (carry[i+1])
    );
  end

  assign stage_tick = carry[STAGES-1:0] & term;
  assign max_tick   = carry[STAGES];

  always_comb begin
    wrap_d = wrap_q;
    if (clr || load) begin
      wrap_d = 1'b0;
    end else if (max_tick) begin
      wrap_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_flag = wrap_q;

endmodule

// File: tb/tb_modm_cascade_counter.sv
// Bench for modm_cascade_counter: a 2-digit decimal instance (A) and a 3-digit mod-6 instance (B).
// The reference model holds each counter as a single integer modulo M**STAGES.
// Ticks are derived from remainders of that integer, not from per-digit logic.
module tb_modm_cascade_counter;

  logic       clk;
  logic       rstb;

  logic       a_clr, a_load, a_en, a_up;
  logic [7:0] a_ld, a_q;
  logic [1:0] a_st;
  logic       a_mx, a_wf;

  logic       b_clr, b_load, b_en, b_up;
  logic [8:0] b_ld, b_q;
  logic [2:0] b_st;
  logic       b_mx, b_wf;

  int checks = 0;
  int errors = 0;

  int va = 0;
  int vb = 0;
  bit wfa = 0;
  bit wfb = 0;

  typedef struct {
    int st_a, st_e, mx_a, mx_e, q_a, q_e, wf_a, wf_e;
  } obs_t;

  modm_cascade_counter #(.M(10), .STAGES(2)) u_dut_a (
    .clk(clk), .rstb(rstb), .clr(a_clr), .load(a_load), .load_val(a_ld),
    .en(a_en), .up(a_up), .q(a_q), .stage_tick(a_st), .max_tick(a_mx), .wrap_flag(a_wf)
  );

  modm_cascade_counter #(.M(6), .STAGES(3)) u_dut_b (
    .clk(clk), .rstb(rstb), .clr(b_clr), .load(b_load), .load_val(b_ld),
    .en(b_en), .up(b_up), .q(b_q), .stage_tick(b_st), .max_tick(b_mx), .wrap_flag(b_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pw(input int b, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * b;
    return r;
  endfunction

  // Stage i wraps when the low i+1 digits, taken as one number, are all-max (up) or zero (down).
  function automatic int exp_stick(input int m, input int s, input int v, input bit c0, input bit dir);
    int r;
    int md;
    r = 0;
    for (int i = 0; i < s; i++) begin
      md = pw(m, i + 1);
      if (c0 && (dir ? ((v % md) == md - 1) : ((v % md) == 0))) r = r | (1 << i);
    end
    return r;
  endfunction

  function automatic int to_q(input int v, input int m, input int s, input int w);
    int r;
    r = 0;
    for (int i = 0; i < s; i++) r = r | (((v / pw(m, i)) % m) << (i * w));
    return r;
  endfunction

  function automatic int from_ld(input int ld, input int m, input int s, input int w);
    int v;
    int dg;
    v = 0;
    for (int i = 0; i < s; i++) begin
      dg = (ld >> (i * w)) & ((1 << w) - 1);
      if (dg >= m) dg = m - 1;
      v = v + dg * pw(m, i);
    end
    return v;
  endfunction

  // Samples comb outputs before the edge, advances the model on the edge,
  // then samples registered outputs just after it.
  task automatic step(input bit sel, output obs_t o);
    int m, s, w, n, v, ldv;
    bit wf, c0, dir, clr_i, ld_i;
    if (!sel) begin
      m = 10; s = 2; w = 4; v = va; wf = wfa;
      clr_i = a_clr; ld_i = a_load; dir = a_up; ldv = int'(a_ld);
      c0 = a_en && !a_clr && !a_load;
    end else begin
      m = 6; s = 3; w = 3; v = vb; wf = wfb;
      clr_i = b_clr; ld_i = b_load; dir = b_up; ldv = int'(b_ld);
      c0 = b_en && !b_clr && !b_load;
    end
    n = pw(m, s);
    #1;
    o.st_e = exp_stick(m, s, v, c0, dir);
    o.mx_e = (c0 && (dir ? (v == n - 1) : (v == 0))) ? 1 : 0;
    o.st_a = sel ? int'(b_st) : int'(a_st);
    o.mx_a = sel ? int'(b_mx) : int'(a_mx);
    @(posedge clk);
    if (clr_i) begin
      v = 0; wf = 0;
    end else if (ld_i) begin
      v = from_ld(ldv, m, s, w); wf = 0;
    end else if (c0) begin
      if (o.mx_e != 0) wf = 1;
      v = dir ? (v + 1) % n : (v + n - 1) % n;
    end
    if (!sel) begin va = v; wfa = wf; end
    else begin vb = v; wfb = wf; end
    #1;
    o.q_e  = to_q(v, m, s, w);
    o.wf_e = wf ? 1 : 0;
    o.q_a  = sel ? int'(b_q) : int'(a_q);
    o.wf_a = sel ? int'(b_wf) : int'(a_wf);
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_ld = '0;
    b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_ld = '0;
    #3;
    checks++; if (a_q !== 8'h00) begin errors++; $display("FAIL rst_q: got %0h expected 0", a_q); end
    checks++; if (a_wf !== 1'b0) begin errors++; $display("FAIL rst_wrap: got %0b expected 0", a_wf); end
    checks++; if (a_st !== 2'b00 || a_mx !== 1'b0) begin
      errors++; $display("FAIL rst_ticks_up: got st=%0b mx=%0b expected 0/0", a_st, a_mx); end
    checks++; if (b_q !== 9'h000) begin errors++; $display("FAIL rst_b_q: got %0h expected 0", b_q); end
    a_up = 0; a_en = 1;
    #1;
    checks++; if (a_st !== 2'b11 || a_mx !== 1'b1) begin
      errors++; $display("FAIL rst_ticks_down: got st=%0b mx=%0b expected 11/1", a_st, a_mx); end
    a_en = 0;
    #1;
    checks++; if (a_st !== 2'b00 || a_mx !== 1'b0) begin
      errors++; $display("FAIL rst_ticks_down_noen: got st=%0b mx=%0b expected 0/0", a_st, a_mx); end
    a_up = 1;
    @(posedge clk); #1;
    rstb = 1'b1;
    va = 0; vb = 0; wfa = 0; wfb = 0;
  endtask

  task automatic test_async_reset();
    obs_t o;
    a_clr = 1; step(0, o); a_clr = 0;
    a_en = 1; a_up = 1;
    repeat (37) step(0, o);
    checks++; if (a_q !== 8'h37) begin errors++; $display("FAIL ar_pre_q: got %0h expected 37", a_q); end
    rstb = 1'b0;
    #1;
    checks++; if (a_q !== 8'h00 || a_wf !== 1'b0) begin
      errors++; $display("FAIL ar_immediate: got q=%0h wf=%0b expected 0/0", a_q, a_wf); end
    va = 0; vb = 0; wfa = 0; wfb = 0;
    @(posedge clk); #1;
    rstb = 1'b1;
    step(0, o);
    checks++; if (o.q_a !== 32'h01) begin errors++; $display("FAIL ar_resume: got %0h expected 01", o.q_a); end
    a_en = 0;
  endtask

  task automatic test_count_up();
    obs_t o;
    int mx_cnt;
    a_clr = 1; step(0, o); a_clr = 0;
    checks++; if (o.q_a !== 0 || o.wf_a !== 0) begin
      errors++; $display("FAIL up_clr: got q=%0h wf=%0d expected 0/0", o.q_a, o.wf_a); end
    a_en = 1; a_up = 1;
    mx_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      step(0, o);
      if (o.mx_a != 0) mx_cnt++;
      checks++; if (o.st_a !== o.st_e) begin errors++; $display("FAIL up_stick k=%0d: got %0b expected %0b", k, o.st_a, o.st_e); end
      checks++; if (o.mx_a !== o.mx_e) begin errors++; $display("FAIL up_max k=%0d: got %0d expected %0d", k, o.mx_a, o.mx_e); end
      checks++; if (o.q_a !== o.q_e) begin errors++; $display("FAIL up_q k=%0d: got %0h expected %0h", k, o.q_a, o.q_e); end
      checks++; if (o.wf_a !== o.wf_e) begin errors++; $display("FAIL up_wrap k=%0d: got %0d expected %0d", k, o.wf_a, o.wf_e); end
    end
    checks++; if (a_q !== 8'h00 || a_wf !== 1'b1) begin
      errors++; $display("FAIL up_end: got q=%0h wf=%0b expected 00/1", a_q, a_wf); end
    checks++; if (mx_cnt != 1) begin errors++; $display("FAIL up_max_count: got %0d expected 1", mx_cnt); end
    a_en = 0;
  endtask

  task automatic test_count_down();
    obs_t o;
    a_clr = 1; step(0, o); a_clr = 0;
    a_en = 1; a_up = 0;
    step(0, o);
    checks++; if (o.mx_a !== 1 || o.st_a !== 3) begin
      errors++; $display("FAIL dn_wrap_ticks: got mx=%0d st=%0b expected 1/11", o.mx_a, o.st_a); end
    checks++; if (o.q_a !== 32'h99) begin errors++; $display("FAIL dn_first: got %0h expected 99", o.q_a); end
    for (int k = 0; k < 10 && a_q !== 8'h95; k++) begin
      step(0, o);
      checks++; if (o.q_a !== o.q_e || o.st_a !== o.st_e || o.mx_a !== o.mx_e) begin
        errors++; $display("FAIL dn_step k=%0d: got q=%0h st=%0b mx=%0d expected %0h/%0b/%0d",
                           k, o.q_a, o.st_a, o.mx_a, o.q_e, o.st_e, o.mx_e); end
    end
    checks++; if (a_q !== 8'h95) begin errors++; $display("FAIL dn_reach95: got %0h expected 95", a_q); end
    a_up = 1;
    step(0, o);
    checks++; if (o.q_a !== 32'h96) begin errors++; $display("FAIL dn_toggle: got %0h expected 96", o.q_a); end
    checks++; if (o.wf_a !== 1) begin errors++; $display("FAIL dn_wrap_flag: got %0d expected 1", o.wf_a); end
    a_en = 0;
  endtask

  task automatic test_load();
    obs_t o;
    a_load = 1; a_ld = 8'h37;
    step(0, o);
    checks++; if (o.q_a !== 32'h37 || o.wf_a !== 0) begin
      errors++; $display("FAIL ld_basic: got q=%0h wf=%0d expected 37/0", o.q_a, o.wf_a); end
    a_ld = 8'hC5;
    step(0, o);
    checks++; if (o.q_a !== 32'h95) begin errors++; $display("FAIL ld_clamp: got %0h expected 95", o.q_a); end
    a_clr = 1; a_ld = 8'h37;
    step(0, o);
    checks++; if (o.q_a !== 32'h00) begin errors++; $display("FAIL ld_clr_prio: got %0h expected 00", o.q_a); end
    a_clr = 0; a_load = 0;
  endtask

  task automatic test_hold_en();
    obs_t o;
    a_load = 1; a_ld = 8'h99;
    step(0, o);
    a_load = 0; a_en = 0; a_up = 1;
    step(0, o);
    checks++; if (o.st_a !== 0 || o.mx_a !== 0) begin
      errors++; $display("FAIL hold_ticks: got st=%0b mx=%0d expected 0/0", o.st_a, o.mx_a); end
    checks++; if (o.q_a !== 32'h99) begin errors++; $display("FAIL hold_q: got %0h expected 99", o.q_a); end
    a_en = 1;
    step(0, o);
    checks++; if (o.mx_a !== 1) begin errors++; $display("FAIL hold_en_max: got %0d expected 1", o.mx_a); end
    checks++; if (o.q_a !== 32'h00 || o.wf_a !== 1) begin
      errors++; $display("FAIL hold_en_q: got q=%0h wf=%0d expected 00/1", o.q_a, o.wf_a); end
    a_en = 0;
  endtask

  task automatic test_m6();
    obs_t o;
    int mx_cnt;
    int max_at;
    bit range_ok;
    b_en = 1; b_up = 1;
    mx_cnt = 0;
    max_at = -1;
    range_ok = 1;
    for (int k = 0; k < 216; k++) begin
      step(1, o);
      if (o.mx_a != 0) begin mx_cnt++; max_at = k; end
      for (int i = 0; i < 3; i++) if (b_q[i*3 +: 3] > 3'd5) range_ok = 0;
      checks++; if (o.q_a !== o.q_e || o.st_a !== o.st_e || o.mx_a !== o.mx_e || o.wf_a !== o.wf_e) begin
        errors++; $display("FAIL m6_step k=%0d: got q=%0h st=%0b mx=%0d wf=%0d expected %0h/%0b/%0d/%0d",
                           k, o.q_a, o.st_a, o.mx_a, o.wf_a, o.q_e, o.st_e, o.mx_e, o.wf_e); end
    end
    checks++; if (!range_ok) begin errors++; $display("FAIL m6_range: got out-of-range digit expected all <= 5"); end
    checks++; if (mx_cnt != 1 || max_at != 215) begin
      errors++; $display("FAIL m6_max_once: got count=%0d at=%0d expected 1 at 215", mx_cnt, max_at); end
    checks++; if (b_q !== 9'h000) begin errors++; $display("FAIL m6_end: got %0h expected 0", b_q); end
    b_en = 0;
  endtask

  task automatic test_random();
    obs_t o;
    for (int k = 0; k < 400; k++) begin
      a_en   = ($urandom_range(0, 3) != 0);
      a_up   = $urandom_range(0, 1) != 0;
      a_clr  = ($urandom_range(0, 15) == 0);
      a_load = ($urandom_range(0, 15) == 0);
      a_ld   = 8'($urandom);
      step(0, o);
      checks++; if (o.q_a !== o.q_e || o.st_a !== o.st_e || o.mx_a !== o.mx_e || o.wf_a !== o.wf_e) begin
        errors++; $display("FAIL rnd_a k=%0d: got q=%0h st=%0b mx=%0d wf=%0d expected %0h/%0b/%0d/%0d",
                           k, o.q_a, o.st_a, o.mx_a, o.wf_a, o.q_e, o.st_e, o.mx_e, o.wf_e); end
    end
    a_en = 0; a_clr = 0; a_load = 0;
    for (int k = 0; k < 300; k++) begin
      b_en   = ($urandom_range(0, 3) != 0);
      b_up   = $urandom_range(0, 1) != 0;
      b_clr  = ($urandom_range(0, 31) == 0);
      b_load = ($urandom_range(0, 15) == 0);
      b_ld   = 9'($urandom);
      step(1, o);
      checks++; if (o.q_a !== o.q_e || o.st_a !== o.st_e || o.mx_a !== o.mx_e || o.wf_a !== o.wf_e) begin
        errors++; $display("FAIL rnd_b k=%0d: got q=%0h st=%0b mx=%0d wf=%0d expected %0h/%0b/%0d/%0d",
                           k, o.q_a, o.st_a, o.mx_a, o.wf_a, o.q_e, o.st_e, o.mx_e, o.wf_e); end
    end
    b_en = 0; b_clr = 0; b_load = 0;
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_hold_en();
    test_m6();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
